// File: rtl/tdm_demux_4ch.sv
// tdm_demux_4ch: 4-channel serial TDM deserialiser with frame-sync lock and sync-error detection
// Ports:
//   clk         system clock, all state on rising edge
//   rst_n       asynchronous active-low reset
//   din         serial TDM data bit
//   din_valid   din and sync are sampled only when high (a "beat")
//   sync        frame marker, high on the slot-0 beat
//   out_a..d    W-bit parallel words for channels a..d (slots 0..3)
//   word_valid  one-cycle pulse when out_a..out_d hold a new word set
//   locked      high while aligned to frame sync
//   sync_err    one-cycle pulse on a sync seen outside slot 0
module tdm_demux_4ch #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         din,
   input  logic         din_valid,
   input  logic         sync,
   output logic [W-1:0] out_a,
   output logic [W-1:0] out_b,
   output logic [W-1:0] out_c,
   output logic [W-1:0] out_d,
   output logic         word_valid,
   output logic         locked,
   output logic         sync_err
);
   localparam int CW = (W > 2) ? $clog2(W) : 1;
   typedef enum logic {HUNT, LOCK} state_t;
   state_t         r_state, w_state;
   logic [1:0]     r_slot, w_slot;
   logic [CW-1:0]  r_bitcnt, w_bitcnt;
   logic [W-1:0]   r_sh [4];
   logic [W-1:0]   w_sh [4];
   logic [W-1:0]   r_out [4];
   logic [W-1:0]   w_out [4];
   logic           r_wv, w_wv, r_err, w_err;
   logic           w_realign, w_shift, w_last;
   // A sync outside slot 0 (or any sync while hunting) restarts the frame group on this beat.
   assign w_realign = din_valid && sync && (r_state == HUNT || r_slot != 2'd0);
   assign w_shift   = din_valid && r_state == LOCK;
   assign w_last    = r_bitcnt == CW'(W - 1);
   always_comb begin
      w_state  = r_state;
      w_slot   = r_slot;
      w_bitcnt = r_bitcnt;
      w_sh     = r_sh;
      w_out    = r_out;
      w_wv     = 1'b0;
      w_err    = 1'b0;
      if (w_realign) begin
         w_state  = LOCK;
         w_slot   = 2'd1;
         w_bitcnt = '0;
         w_err    = r_state == LOCK;
         w_sh     = '{default: '0};
         w_sh[0]  = W'(din);
      end else if (w_shift) begin
         w_sh[r_slot] = {r_sh[r_slot][W-2:0], din};
         w_slot       = r_slot + 2'd1;
         if (r_slot == 2'd3) begin
            w_bitcnt = w_last ? '0 : r_bitcnt + CW'(1);
            // Word set completes on the slot-3 beat of the last bit; publish including that bit.
            if (w_last) begin
               w_out = w_sh;
               w_wv  = 1'b1;
            end
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= HUNT;
         r_slot   <= '0;
         r_bitcnt <= '0;
         r_sh     <= '{default: '0};
         r_out    <= '{default: '0};
         r_wv     <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_slot   <= w_slot;
         r_bitcnt <= w_bitcnt;
         r_sh     <= w_sh;
         r_out    <= w_out;
         r_wv     <= w_wv;
         r_err    <= w_err;
      end
   end
   assign out_a      = r_out[0];
   assign out_b      = r_out[1];
   assign out_c      = r_out[2];
   assign out_d      = r_out[3];
   assign word_valid = r_wv;
   assign locked     = r_state == LOCK;
   assign sync_err   = r_err;
endmodule

// File: tb/tb_tdm_demux_4ch.sv
// tb_tdm_demux_4ch: scoreboard bench for tdm_demux_4ch (W=8)
module tb_tdm_demux_4ch;
   localparam int W = 8;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         din = 1'b0;
   logic         din_valid = 1'b0;
   logic         sync = 1'b0;
   logic [W-1:0] out_a, out_b, out_c, out_d;
   logic         word_valid, locked, sync_err;
   int           checks = 0;
   int           failures = 0;
   int           cyc = 0;
   int           last_wv = -1;
   int           prev_wv = -1;
   typedef struct {
      logic [31:0] w;
      int          c;
   } exp_t;
   exp_t q[$];

   tdm_demux_4ch #(.W(W)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sync(sync),
      .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
      .word_valid(word_valid), .locked(locked), .sync_err(sync_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Every word_valid must match the oldest expected word set, in the predicted cycle.
   always @(posedge clk) begin
      #1;
      if (word_valid) begin
         if (q.size() == 0) check("wv_unexpected", 32'd1, 32'd0);
         else begin
            exp_t e;
            e = q.pop_front();
            check("out_abcd", {out_a, out_b, out_c, out_d}, e.w);
            check("wv_cycle", cyc, e.c);
         end
         prev_wv = last_wv;
         last_wv = cyc;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic d, input logic s);
      din = d;
      sync = s;
      din_valid = 1'b1;
      @(negedge clk);
      din_valid = 1'b0;
      sync = 1'b0;
   endtask

   // Sends the first nb beats of a word set, MSB first, interleaved a,b,c,d, sync on slot 0.
   task automatic send_set(input logic [31:0] w, input int nb, input bit gaps, input bit exp_err);
      for (int k = 0; k < nb; k++) begin
         int bi, ch;
         bi = k / 4;
         ch = k % 4;
         if (nb == 4 * W && k == nb - 1) q.push_back('{w: w, c: cyc + 1});
         send(w[31 - 8 * ch - bi], ch == 0);
         if (k == 0) begin
            check("locked_after_sync", locked, 1'b1);
            check("sync_err", sync_err, exp_err);
         end
         if (gaps && $urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end
   endtask

   initial begin
      #1;
      check("rst_outs", {out_a, out_b, out_c, out_d}, 32'd0);
      check("rst_flags", {word_valid, locked, sync_err}, 3'b000);
      idle(2);
      rst_n = 1'b1;
      idle(1);
      for (int i = 0; i < 10; i++) send(1'($urandom_range(0, 1)), 1'b0);
      idle(1);
      check("hunt_locked", locked, 1'b0);
      check("hunt_outs", {out_a, out_b, out_c, out_d}, 32'd0);
      send_set(32'hA53CFF01, 32, 1'b0, 1'b0);
      idle(3);
      send_set(32'hA53CFF01, 32, 1'b1, 1'b0);
      idle(3);
      check("outs_hold", {out_a, out_b, out_c, out_d}, 32'hA53CFF01);
      send_set(32'h12345678, 14, 1'b0, 1'b0);
      send_set(32'h81422418, 32, 1'b0, 1'b1);
      idle(3);
      send_set(32'h55AA55AA, 20, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_outs", {out_a, out_b, out_c, out_d}, 32'd0);
      check("async_rst_flags", {word_valid, locked, sync_err}, 3'b000);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) send(1'(i % 2), 1'b0);
      check("post_rst_hunt", locked, 1'b0);
      send_set(32'h11223344, 32, 1'b0, 1'b0);
      send_set(32'hEEDDCCBB, 32, 1'b0, 1'b0);
      idle(3);
      check("wv_gap", last_wv - prev_wv, 32'd32);
      check("final_outs", {out_a, out_b, out_c, out_d}, 32'hEEDDCCBB);
      check("sb_empty", q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
